// File: rtl/pow2_rr_arbiter.sv
// Round-robin arbiter sharing one power-of-two exponent unit among NREQ requesters.
// The winning operand is converted combinationally and the result is registered
// together with the ID of the requester that produced it.
module pow2_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [6*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic [2:0]        res_pow,
    input  logic              res_ready
);

    logic [IDW-1:0] ptr_q;
    logic           res_valid_q;
    logic [IDW-1:0] res_id_q;
    logic [2:0]     res_pow_q;

    logic           can_accept;
    logic           grant_any;
    logic           grant_fire;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   cand;
    logic [5:0]     grant_x;
    logic [5:0]     grant_xm1;
    logic [2:0]     grant_pow;
    logic [IDW-1:0] next_ptr;

    assign can_accept = !res_valid_q || res_ready;

    // First valid requester at or above ptr, wrapping at NREQ-1.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (cand >= (IDW + 1)'(NREQ)) begin
                cand = cand - (IDW + 1)'(NREQ);
            end
            if (!grant_any && req_valid[cand[IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = cand[IDW-1:0];
            end
        end
    end

    // Exponent: 0 for x<=2, else index of the MSB of x-1.
    always_comb begin
        grant_x   = req_data[6*grant_id +: 6];
        grant_xm1 = grant_x - 6'd1;
        grant_pow = 3'd0;
        if (grant_x > 6'd2) begin
            for (int i = 0; i < 6; i++) begin
                if (grant_xm1[i]) begin
                    grant_pow = 3'(i);
                end
            end
        end
    end

    // Grant is suppressed while in reset or while the result register is stalled.
    always_comb begin
        grant_fire = can_accept && grant_any && !rst;
        req_ready  = '0;
        if (grant_fire) begin
            req_ready = NREQ'(1) << grant_id;
        end
        if (grant_id == IDW'(NREQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_id + IDW'(1);
        end
    end

    // Result register and round-robin pointer; ptr moves only on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_pow_q   <= '0;
        end else if (grant_fire) begin
            ptr_q       <= next_ptr;
            res_valid_q <= 1'b1;
            res_id_q    <= grant_id;
            res_pow_q   <= grant_pow;
        end else if (res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_pow   = res_pow_q;

endmodule

// File: tb/tb_pow2_rr_arbiter.sv
// Self-checking bench for pow2_rr_arbiter (NREQ=4): directed vector table,
// exponent sweep and randomized traffic against a behavioural model.
module tb_pow2_rr_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [6*N-1:0] req_data;
    logic [N-1:0] req_ready;
    logic         res_valid;
    logic [1:0]   res_id;
    logic [2:0]   res_pow;
    logic         res_ready;

    pow2_rr_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_pow   (res_pow),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int m_ptr = 0;
    int m_v   = 0;
    int m_id  = 0;
    int m_pow = 0;
    int m_g   = -1;
    logic [N-1:0] obs_ready;

    function automatic int f_ref(input int x);
        int c;
        if (x <= 2) return 0;
        c = 0;
        while ((1 << c) < x) c++;
        return c - 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, checking against the model before and after the edge.
    task automatic cycle(input bit r, input logic [N-1:0] v, input logic [6*N-1:0] d,
                         input bit rr);
        int exp_ready;
        rst = r; req_valid = v; req_data = d; res_ready = rr;
        m_g = -1;
        if (!r && (m_v == 0 || rr)) begin
            for (int k = 0; k < N; k++) begin
                if (m_g < 0 && v[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
            end
        end
        exp_ready = (m_g < 0) ? 0 : (1 << m_g);
        #1;
        obs_ready = req_ready;
        chk("model req_ready", int'(req_ready), exp_ready);
        @(posedge clk);
        if (r) begin
            m_ptr = 0; m_v = 0; m_id = 0; m_pow = 0;
        end else if (m_g >= 0) begin
            m_v = 1; m_id = m_g; m_pow = f_ref(int'(d[6*m_g +: 6])); m_ptr = (m_g + 1) % N;
        end else if (rr) begin
            m_v = 0;
        end
        #1;
        chk("model res_valid", int'(res_valid), m_v);
        chk("model res_id", int'(res_id), m_id);
        chk("model res_pow", int'(res_pow), m_pow);
        @(negedge clk);
    endtask

    typedef struct {
        bit           r;
        logic [N-1:0] v;
        logic [23:0]  d;
        bit           rr;
        logic [N-1:0] e_ready;
        int           e_v;
        int           e_id;
        int           e_pow;
    } vec_t;

    localparam logic [23:0] D_RR = {6'd17, 6'd9, 6'd5, 6'd3};
    localparam logic [23:0] D_BP = {6'd0, 6'd20, 6'd40, 6'd0};

    vec_t tbl[26];
    int   pend[N];
    logic [5:0] pdata[N];
    int   waitc[N];

    initial begin
        // reset + round-robin with all requesters
        tbl[0]  = '{1, 4'hF, D_RR, 1, 4'b0000, 0, 0, 0};
        tbl[1]  = '{0, 4'hF, D_RR, 1, 4'b0001, 1, 0, 1};
        tbl[2]  = '{0, 4'hF, D_RR, 1, 4'b0010, 1, 1, 2};
        tbl[3]  = '{0, 4'hF, D_RR, 1, 4'b0100, 1, 2, 3};
        tbl[4]  = '{0, 4'hF, D_RR, 1, 4'b1000, 1, 3, 4};
        tbl[5]  = '{0, 4'hF, D_RR, 1, 4'b0001, 1, 0, 1};
        tbl[6]  = '{0, 4'hF, D_RR, 1, 4'b0010, 1, 1, 2};
        // sparse 1010 from ptr=0
        tbl[7]  = '{1, 4'hA, D_RR, 1, 4'b0000, 0, 0, 0};
        tbl[8]  = '{0, 4'hA, D_RR, 1, 4'b0010, 1, 1, 2};
        tbl[9]  = '{0, 4'hA, D_RR, 1, 4'b1000, 1, 3, 4};
        tbl[10] = '{0, 4'hA, D_RR, 1, 4'b0010, 1, 1, 2};
        // idle drain, pointer kept across idle cycles
        tbl[11] = '{0, 4'h0, D_RR, 1, 4'b0000, 0, 1, 2};
        tbl[12] = '{0, 4'h1, D_RR, 1, 4'b0001, 1, 0, 1};
        tbl[13] = '{0, 4'h0, D_RR, 1, 4'b0000, 0, 0, 1};
        tbl[14] = '{0, 4'h0, D_RR, 1, 4'b0000, 0, 0, 1};
        tbl[15] = '{0, 4'hF, D_RR, 1, 4'b0010, 1, 1, 2};
        // backpressure
        tbl[16] = '{0, 4'h4, D_BP, 1, 4'b0100, 1, 2, 4};
        tbl[17] = '{0, 4'h2, D_BP, 0, 4'b0000, 1, 2, 4};
        tbl[18] = '{0, 4'h2, D_BP, 0, 4'b0000, 1, 2, 4};
        tbl[19] = '{0, 4'h2, D_BP, 0, 4'b0000, 1, 2, 4};
        tbl[20] = '{0, 4'h2, D_BP, 0, 4'b0000, 1, 2, 4};
        tbl[21] = '{0, 4'h2, D_BP, 0, 4'b0000, 1, 2, 4};
        tbl[22] = '{0, 4'h2, D_BP, 1, 4'b0010, 1, 1, 5};
        // reset mid-stream with a stalled result and pending requests
        tbl[23] = '{0, 4'hC, D_BP, 0, 4'b0000, 1, 1, 5};
        tbl[24] = '{1, 4'hC, D_BP, 0, 4'b0000, 0, 0, 0};
        tbl[25] = '{0, 4'hC, D_BP, 1, 4'b0100, 1, 2, 4};

        rst = 1'b1; req_valid = '0; req_data = '0; res_ready = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 26; i++) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].rr);
            chk($sformatf("vec%0d req_ready", i), int'(obs_ready), int'(tbl[i].e_ready));
            chk($sformatf("vec%0d res_valid", i), int'(res_valid), tbl[i].e_v);
            chk($sformatf("vec%0d res_id", i), int'(res_id), tbl[i].e_id);
            chk($sformatf("vec%0d res_pow", i), int'(res_pow), tbl[i].e_pow);
        end

        // exponent sweep on requester 0
        for (int x = 0; x < 64; x++) begin
            int e;
            e = (x <= 2) ? 0 : (x <= 4) ? 1 : (x <= 8) ? 2 : (x <= 16) ? 3 : (x <= 32) ? 4 : 5;
            cycle(0, 4'b0001, {18'd0, 6'(x)}, 1);
            chk($sformatf("sweep x=%0d req_ready", x), int'(obs_ready), 1);
            chk($sformatf("sweep x=%0d res_valid", x), int'(res_valid), 1);
            chk($sformatf("sweep x=%0d res_id", x), int'(res_id), 0);
            chk($sformatf("sweep x=%0d res_pow", x), int'(res_pow), e);
        end

        // randomized traffic; requesters hold operands until granted
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; pdata[i] = '0; waitc[i] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] v;
            logic [6*N-1:0] d;
            bit r;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 45) begin
                    pend[i] = 1; pdata[i] = 6'($urandom_range(0, 63)); waitc[i] = 0;
                end
                v[i] = pend[i] != 0;
                d[6*i +: 6] = pdata[i];
            end
            r = ($urandom_range(0, 59) == 0);
            cycle(r, v, d, $urandom_range(0, 3) != 0);
            if (r) begin
                for (int i = 0; i < N; i++) waitc[i] = 0;
            end else if (m_g >= 0) begin
                tests++;
                if (waitc[m_g] >= N) begin
                    fails++;
                    $display("FAIL fairness req%0d: waited %0d grants, limit %0d",
                             m_g, waitc[m_g] + 1, N);
                end
                pend[m_g] = 0;
                for (int i = 0; i < N; i++) begin
                    if (i != m_g && pend[i] != 0) waitc[i]++;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
